// File: rtl/fixed_matmul_in2_replay_pkg.sv
// Shared types and width helpers for the data_in2 tile replay buffer.
package fixed_matmul_replay_pkg;

  typedef enum logic {FILL, REPLAY} replay_state_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int pass_width(input int passes);
    return (passes > 1) ? $clog2(passes) : 1;
  endfunction

endpackage

// File: rtl/fixed_matmul_in2_replay_if.sv
// Tile stream bundle between the weight fetch, the replay buffer and the matmul core.
interface fixed_matmul_in2_replay_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARALLELISM = 3
);
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] data_in;
  logic                                   data_in_valid;
  logic                                   data_in_ready;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] data_out;
  logic                                   data_out_valid;
  logic                                   data_out_ready;

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/fixed_matmul_in2_replay_tile_buffer_regs.sv
// DEPTH-entry tile register file: one synchronous write port, one combinational read port.
module tile_buffer_regs #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARALLELISM = 3,
  parameter int DEPTH       = 3,
  parameter int PW          = 2
) (
  input  logic                                   clk,
  input  logic                                   wr_en,
  input  logic [PW-1:0]                          wr_addr,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic [PW-1:0]                          rd_addr,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rd_data
);
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset; contents are always rewritten before being replayed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fixed_matmul_in2_replay.sv
// Weight tile replay buffer: forwards one pass of DEPTH tiles, then re-issues it REPEAT-1 times.
//   state  | meaning
//   FILL   | accept upstream tiles, write-through to output register and buffer
//   REPLAY | upstream stalled, output register reloaded from buffer[rd_ptr]
module fixed_matmul_in2_replay
  import fixed_matmul_replay_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PARALLELISM = 3,
  parameter int DEPTH       = 3,
  parameter int REPEAT      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fixed_matmul_in2_replay_if.slave   bus
);
  localparam int PW = ptr_width(DEPTH);
  localparam int CW = pass_width(REPEAT);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] PASS_LAST = CW'(REPEAT - 1);

  typedef logic [PARALLELISM-1:0][DATA_WIDTH-1:0] tile_t;

  replay_state_t state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] pass_cnt, pass_cnt_nxt;
  tile_t         out_data, out_data_nxt, rd_data;
  logic          out_valid, out_valid_nxt;
  logic          out_free, accept, replay_load;

  assign out_free          = !out_valid || bus.data_out_ready;
  assign bus.data_in_ready = (state == FILL) && out_free && !rst;
  assign accept            = bus.data_in_valid && bus.data_in_ready;
  assign replay_load       = (state == REPLAY) && out_free;
  assign bus.data_out       = out_data;
  assign bus.data_out_valid = out_valid;

  tile_buffer_regs #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARALLELISM(PARALLELISM),
    .DEPTH      (DEPTH),
    .PW         (PW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (accept),
    .wr_addr(wr_ptr),
    .wr_data(bus.data_in),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pass_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      pass_cnt  <= pass_cnt_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    pass_cnt_nxt  = pass_cnt;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    if (accept) begin
      out_data_nxt  = bus.data_in;
      out_valid_nxt = 1'b1;
      if (wr_ptr == PTR_LAST) begin
        wr_ptr_nxt = '0;
        // The fill itself is pass 0, so replay starts counting at 1.
        if (REPEAT > 1) begin
          state_nxt    = REPLAY;
          pass_cnt_nxt = CW'(1);
          rd_ptr_nxt   = '0;
        end
      end else begin
        wr_ptr_nxt = wr_ptr + 1'b1;
      end
    end else if (replay_load) begin
      out_data_nxt  = rd_data;
      out_valid_nxt = 1'b1;
      if (rd_ptr == PTR_LAST) begin
        rd_ptr_nxt = '0;
        if (pass_cnt == PASS_LAST) begin
          state_nxt    = FILL;
          pass_cnt_nxt = '0;
        end else begin
          pass_cnt_nxt = pass_cnt + 1'b1;
        end
      end else begin
        rd_ptr_nxt = rd_ptr + 1'b1;
      end
    end else if (bus.data_out_ready) begin
      out_valid_nxt = 1'b0;
    end
  end
endmodule
